sipo_word_collector: RTL

//  Receive end of the serial shift-register link: takes the serial bit stream that a

---
 rtl/sreg_pkg.sv | 18 +
 rtl/sipo_shift_core.sv | 79 +++++++
 rtl/sipo_word_collector.sv | 95 +++++++++
 3 files changed

// File: rtl/sreg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sreg_pkg
// Description : Constants shared by the serial shift-register link (transmit
//               parallel-load shift register and receive word collector).
// Revision    : 1.0 - initial release
// ============================================================================
package sreg_pkg;

   // Shift direction encodings, common to both ends of the link
   localparam int SHIFT_RIGHT = 1;   // LSB first, new bit enters at the MSB
   localparam int SHIFT_LEFT  = 0;   // MSB first, new bit enters at the LSB

   // Default word width of the link
   localparam int SHIFT_WIDTH_DEFAULT = 8;

endpackage : sreg_pkg
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_core
// Description : Serial-in shift register plus bit counter. Flags the cycle in
//               which the last bit of a word arrives and presents the complete
//               word (including that bit) combinationally on the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_core
   import sreg_pkg::*;
#(
   parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEFAULT,
   parameter int SHIFT_DIR   = SHIFT_RIGHT,
   parameter int CNT_W       = $clog2(SHIFT_WIDTH)
) (
   input  logic                   clk,
   input  logic                   aclr_n,
   input  logic                   sclr,
   input  logic                   en,
   input  logic                   sof,
   input  logic                   shiftin,
   output logic [SHIFT_WIDTH-1:0] word_o,
   output logic                   word_done_o,
   output logic [CNT_W-1:0]       bit_cnt_o
);

   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(SHIFT_WIDTH - 1);
   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

   logic [SHIFT_WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [SHIFT_WIDTH-1:0] w_shifted;

   // Register contents after absorbing shiftin, direction fixed at elaboration
   generate
      if (SHIFT_DIR == SHIFT_RIGHT) begin : g_dir_right
         assign w_shifted = {shiftin, shreg_q[SHIFT_WIDTH-1:1]};
      end else begin : g_dir_left
         assign w_shifted = {shreg_q[SHIFT_WIDTH-2:0], shiftin};
      end
   endgenerate

   // Next-state: shift on every strobe; sof restarts the count at this bit
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (en) begin
         shreg_d = w_shifted;
         if (sof) begin
            cnt_d = C_ONE;
         end else if (cnt_q == C_LAST_BIT) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + C_ONE;
         end
      end
   end

   // State registers with async reset and synchronous clear
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (sclr) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // A sof bit is always bit 0, so it can never complete a word
   assign word_done_o = en && !sof && (cnt_q == C_LAST_BIT);
   assign word_o      = w_shifted;
   assign bit_cnt_o   = cnt_q;

endmodule : sipo_shift_core
`default_nettype wire

// File: rtl/sipo_word_collector.sv
`default_nettype none
// ============================================================================
// Module      : sipo_word_collector
// Description : Receive end of the serial shift-register link. Reassembles
//               the serial stream into words and holds each completed word in
//               a one-entry valid/ready buffer; a word completed while the
//               buffer is full and not being drained sets a sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_word_collector
   import sreg_pkg::*;
#(
   parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEFAULT,
   parameter int SHIFT_DIR   = SHIFT_RIGHT
) (
   input  logic                           clk,
   input  logic                           aclr_n,
   input  logic                           sclr,
   input  logic                           en,
   input  logic                           sof,
   input  logic                           shiftin,
   output logic [SHIFT_WIDTH-1:0]         q,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           overrun,
   output logic [$clog2(SHIFT_WIDTH)-1:0] bit_cnt
);

   localparam int CNT_W = $clog2(SHIFT_WIDTH);

   logic [SHIFT_WIDTH-1:0] w_word;
   logic                   w_word_done;

   logic [SHIFT_WIDTH-1:0] q_q, q_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;

   sipo_shift_core #(
      .SHIFT_WIDTH (SHIFT_WIDTH),
      .SHIFT_DIR   (SHIFT_DIR),
      .CNT_W       (CNT_W)
   ) u_core (
      .clk         (clk),
      .aclr_n      (aclr_n),
      .sclr        (sclr),
      .en          (en),
      .sof         (sof),
      .shiftin     (shiftin),
      .word_o      (w_word),
      .word_done_o (w_word_done),
      .bit_cnt_o   (bit_cnt)
   );

   // Buffer next-state: drain on accept, refill on completion if the slot is
   // free or being freed this edge, otherwise drop the word and flag overrun
   always_comb begin
      q_d     = q_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (w_word_done) begin
         if (!valid_q || out_ready) begin
            q_d     = w_word;
            valid_d = 1'b1;
         end else begin
            ovr_d   = 1'b1;
         end
      end
   end

   // Output buffer and overrun flag registers
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         q_q     <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (sclr) begin
         q_q     <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         q_q     <= q_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign q         = q_q;
   assign out_valid = valid_q;
   assign overrun   = ovr_q;

endmodule : sipo_word_collector
`default_nettype wire
